modulator: RTL and testbench
============================

MODULATOR -- requirements
Module: modulator

Interface
REQ-001 Parameter OUTPUT_WIDTH, default 12, sets the sample width of the carrier and the transmit signal.
REQ-002 Parameter SYMBOL_LEN, default 256, sets the clocks per transmitted bit; legal range 2..256.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 mode_sel  input  1  modulation select: 0 = BPSK, 1 = ASK.
REQ-006 data_in  input  8  byte to transmit, sent MSB first.
REQ-007 data_valid  input  1  data_in is valid.
REQ-008 data_ready  output  1  block accepts a byte this cycle.
REQ-009 sine_c  input  OUTPUT_WIDTH  local carrier sample, reinterpreted as two's-complement signed.
REQ-010 tx_sig  output  OUTPUT_WIDTH signed  modulated transmit sample.
REQ-011 tx_active  output  1  high while a bit (preamble or data) is on air.
REQ-012 bit_strobe  output  1  one-cycle pulse on the last sample of every transmitted bit.

Function
REQ-013 The FSM SHALL have states IDLE, PRE and DATA; PRE exists only when MOD_PREAMBLE_EN is defined.
REQ-014 A byte SHALL be accepted on a rising clk edge where data_valid and data_ready are both 1; the byte and mode_sel are latched together at acceptance.
REQ-015 data_ready SHALL be 1 in IDLE, and in DATA only on the last sample of bit 0 (back-to-back acceptance); 0 otherwise.
REQ-016 A sample counter SHALL run 0..SYMBOL_LEN-1 in PRE and DATA; at SYMBOL_LEN-1 it wraps to 0, bit_strobe pulses, and the next bit is loaded.
REQ-017 After acceptance in IDLE, the first bit SHALL begin on the next cycle (counter = 0).
REQ-018 After the last data bit: if a byte is accepted that cycle, DATA restarts with bit 7 of the new byte without gap and without preamble; otherwise the FSM returns to IDLE.
REQ-019 BPSK: bit 1 -> tx_sig = sine_c; bit 0 -> tx_sig = -sine_c, with -(-2^(W-1)) saturated to 2^(W-1)-1.
REQ-020 ASK: bit 1 -> tx_sig = sine_c; bit 0 -> tx_sig = 0.
REQ-021 tx_sig SHALL be registered: sample n of a bit reflects sine_c from the cycle of counter = n, appearing one cycle later.
REQ-022 In IDLE, tx_sig SHALL be 0 and tx_active SHALL be 0; tx_active is 1 exactly for cycles whose registered tx_sig belongs to a bit.
REQ-023 mode_sel changes during a byte SHALL NOT affect that byte.
REQ-024 data_valid without data_ready SHALL be ignored; data_in need not be held after acceptance.

Reset
REQ-025 While rst = 0: FSM = IDLE, counter = 0, bit index = 7, shift/mode latches = 0, tx_sig = 0, tx_active = 0, bit_strobe = 0, data_ready = 0.
REQ-026 The first cycle after rst releases SHALL present data_ready = 1.
REQ-027 Reset asserted mid-byte SHALL abort immediately; the partial byte is discarded and never resumed.

Configuration
REQ-028 Macro MOD_PREAMBLE_EN: when defined, every byte accepted from IDLE is preceded by 8 preamble bits 1,0,1,0,1,0,1,0 (PRE state, same modulation and timing as data, bit_strobe per bit); data_ready = 0 throughout PRE.
REQ-029 When MOD_PREAMBLE_EN is not defined, PRE and its logic are absent and acceptance from IDLE goes directly to DATA.

Verification
REQ-030 BPSK, sine_c = 100 constant, byte 0x80 -> 256 cycles tx_sig = +100, then 1792 cycles tx_sig = -100, tx_active high 2048 cycles, 8 bit_strobes.
REQ-031 ASK, sine_c = 500, byte 0xA5 -> per-bit tx_sig levels 500,0,500,0,0,500,0,500; then IDLE with tx_sig = 0.
REQ-032 BPSK, sine_c = -2048 (W=12), bit 0 -> tx_sig = 2047 (saturation).
REQ-033 Bytes 0x0F then 0xF0 with data_valid held high -> second byte accepted on the last sample of the first byte's bit 0, no idle cycle between bytes, 16 contiguous bits.
REQ-034 rst = 0 asserted at sample 100 of bit 3 -> tx_sig, tx_active = 0 asynchronously; after release data_ready = 1, next byte starts at bit 7.
REQ-035 With MOD_PREAMBLE_EN, byte 0xFF from IDLE, ASK, sine_c = 300 -> 8 preamble bits 300,0,300,0,300,0,300,0 then 8 bits of 300, 16 bit_strobes.

Source files
------------

// File: rtl/modulator.sv
// BPSK/ASK bit modulator: serialises bytes MSB first, SYMBOL_LEN carrier samples per bit.
// Define MOD_PREAMBLE_EN to send a 1,0,1,0,1,0,1,0 preamble before each byte accepted from IDLE.
module modulator #(
  parameter int OUTPUT_WIDTH = 12,
  parameter int SYMBOL_LEN   = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mode_sel,
  input  logic [7:0]                     data_in,
  input  logic                           data_valid,
  output logic                           data_ready,
  input  logic [OUTPUT_WIDTH-1:0]        sine_c,
  output logic signed [OUTPUT_WIDTH-1:0] tx_sig,
  output logic                           tx_active,
  output logic                           bit_strobe
);
  localparam int CNT_W = (SYMBOL_LEN > 2) ? $clog2(SYMBOL_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_LEN - 1);
  localparam logic signed [OUTPUT_WIDTH-1:0] S_MAX = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUTPUT_WIDTH-1:0] S_MIN = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
`ifdef MOD_PREAMBLE_EN
  localparam logic [7:0] PREAMBLE = 8'hAA;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef MOD_PREAMBLE_EN
    PRE  = 2'd2,
`endif
    DATA = 2'd1
  } state_t;

  state_t                           state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [2:0]                       bit_idx_q, bit_idx_d;
  logic [7:0]                       shift_q, shift_d;
  logic                             mode_q, mode_d;
  logic signed [OUTPUT_WIDTH-1:0]   tx_q, tx_d;
  logic                             active_q, active_d;
  logic                             strobe_q, strobe_d;

  logic                             last_sample;
  logic                             accept;
  logic                             cur_bit;
  logic signed [OUTPUT_WIDTH-1:0]   sine_s;
  logic signed [OUTPUT_WIDTH-1:0]   sine_neg;

  assign sine_s      = $signed(sine_c);
  // Negating the most negative sample would wrap, so clamp it to full scale.
  assign sine_neg    = (sine_s == S_MIN) ? S_MAX : -sine_s;
  assign last_sample = (cnt_q == CNT_LAST);
  assign data_ready  = rst & ((state_q == IDLE) |
                              ((state_q == DATA) & (bit_idx_q == 3'd0) & last_sample));
  assign accept      = data_valid & data_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    mode_d    = mode_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef MOD_PREAMBLE_EN
          state_d = PRE;
`else
          state_d = DATA;
`endif
          cnt_d     = '0;
          bit_idx_d = 3'd7;
          shift_d   = data_in;
          mode_d    = mode_sel;
        end
      end
      DATA: begin
        cnt_d = last_sample ? '0 : cnt_q + 1'b1;
        if (last_sample) begin
          if (bit_idx_q != 3'd0) begin
            bit_idx_d = bit_idx_q - 3'd1;
          end else if (accept) begin
            bit_idx_d = 3'd7;
            shift_d   = data_in;
            mode_d    = mode_sel;
          end else begin
            state_d = IDLE;
          end
        end
      end
`ifdef MOD_PREAMBLE_EN
      PRE: begin
        cnt_d = last_sample ? '0 : cnt_q + 1'b1;
        if (last_sample) begin
          if (bit_idx_q != 3'd0) begin
            bit_idx_d = bit_idx_q - 3'd1;
          end else begin
            state_d   = DATA;
            bit_idx_d = 3'd7;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_bit = shift_q[bit_idx_q];
`ifdef MOD_PREAMBLE_EN
    if (state_q == PRE) cur_bit = PREAMBLE[bit_idx_q];
`endif
    active_d = (state_q != IDLE);
    strobe_d = active_d & last_sample;
    tx_d     = '0;
    if (active_d) begin
      if (cur_bit)     tx_d = sine_s;
      else if (!mode_q) tx_d = sine_neg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd7;
      shift_q   <= '0;
      mode_q    <= 1'b0;
      tx_q      <= '0;
      active_q  <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      mode_q    <= mode_d;
      tx_q      <= tx_d;
      active_q  <= active_d;
      strobe_q  <= strobe_d;
    end
  end

  assign tx_sig     = tx_q;
  assign tx_active  = active_q;
  assign bit_strobe = strobe_q;

endmodule

// File: tb/tb_modulator.sv
// Randomised bench for modulator: a queue-of-bits reference model predicts every output cycle.
// Honours MOD_PREAMBLE_EN the same way the design does.
module tb_modulator;
  localparam int W = 12;
  localparam int L = 8;
`ifdef MOD_PREAMBLE_EN
  localparam int P = 8;
`else
  localparam int P = 0;
`endif
  localparam int SMAX = (1 << (W - 1)) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                mode_sel = 1'b0;
  logic [7:0]          data_in = 8'h00;
  logic                data_valid = 1'b0;
  logic                data_ready;
  logic [W-1:0]        sine_c = '0;
  logic signed [W-1:0] tx_sig;
  logic                tx_active;
  logic                bit_strobe;

  modulator #(.OUTPUT_WIDTH(W), .SYMBOL_LEN(L)) dut (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .sine_c(sine_c),
    .tx_sig(tx_sig), .tx_active(tx_active), .bit_strobe(bit_strobe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, want, $time);
    end
  endtask

  // Reference model: bits still to be sent, front element is on air; pos = sample index in it.
  typedef struct packed { logic val; logic mode; } bit_t;
  bit_t q[$];
  int   pos = 0;
  logic signed [W-1:0] exp_tx = '0;
  logic exp_active = 1'b0;
  logic exp_strobe = 1'b0;

  function automatic logic signed [W-1:0] sat_neg(input logic signed [W-1:0] s);
    int n;
    n = -int'(s);
    if (n > SMAX) n = SMAX;
    return W'(n);
  endfunction

  function automatic logic signed [W-1:0] rnd_sine();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return {1'b1, {(W-1){1'b0}}};
    if (sel == 1) return {1'b0, {(W-1){1'b1}}};
    return W'($urandom);
  endfunction

  // Called just after a falling edge: check outputs, drive inputs, advance model one clock.
  task automatic step(input logic v, input logic [7:0] d, input logic m,
                      input logic signed [W-1:0] s, output logic acc);
    logic exp_ready;
    logic was_idle;
    bit_t b;
    check("tx_sig", tx_sig, exp_tx);
    check("tx_active", {31'b0, tx_active}, {31'b0, exp_active});
    check("bit_strobe", {31'b0, bit_strobe}, {31'b0, exp_strobe});
    exp_ready = (q.size() == 0) || (q.size() == 1 && pos == L - 1);
    check("data_ready", {31'b0, data_ready}, {31'b0, exp_ready});
    data_valid = v;
    data_in    = d;
    mode_sel   = m;
    sine_c     = s;
    was_idle   = (q.size() == 0);
    if (!was_idle) begin
      b = q[0];
      if (b.val)       exp_tx = s;
      else if (b.mode) exp_tx = '0;
      else             exp_tx = sat_neg(s);
      exp_active = 1'b1;
      exp_strobe = (pos == L - 1);
      if (pos == L - 1) begin
        void'(q.pop_front());
        pos = 0;
      end else begin
        pos++;
      end
    end else begin
      exp_tx = '0;
      exp_active = 1'b0;
      exp_strobe = 1'b0;
    end
    acc = v && exp_ready;
    if (acc) begin
      if (was_idle)
        for (int i = 0; i < P; i++) q.push_back('{val: ((i % 2) == 0), mode: m});
      for (int i = 7; i >= 0; i--) q.push_back('{val: d[i], mode: m});
      $display("accept byte=%02h mode=%0d t=%0t", d, m, $time);
    end
    @(negedge clk);
  endtask

  task automatic single_byte(input logic [7:0] d, input logic m, input logic signed [W-1:0] s);
    logic acc;
    int act = 0;
    int stb = 0;
    for (int i = 0; i < (P + 8) * L + 4; i++) begin
      if (tx_active === 1'b1) act++;
      if (bit_strobe === 1'b1) stb++;
      step(i == 0, d, m, s, acc);
    end
    check("byte_active_cycles", act, (P + 8) * L);
    check("byte_strobes", stb, P + 8);
  endtask

  initial begin
    logic acc;
    int k;
    int act;
    repeat (3) @(negedge clk);
    check("rst_tx_sig", tx_sig, 0);
    check("rst_tx_active", {31'b0, tx_active}, 0);
    check("rst_bit_strobe", {31'b0, bit_strobe}, 0);
    check("rst_data_ready", {31'b0, data_ready}, 0);
    rst = 1'b1;
    #1;
    check("post_rst_ready", {31'b0, data_ready}, 1);

    single_byte(8'h80, 1'b0, 12'sd100);
    single_byte(8'hA5, 1'b1, 12'sd500);
    single_byte(8'h55, 1'b0, -12'sd2048);
    single_byte(8'hFF, 1'b1, 12'sd300);

    // Back-to-back: second byte must be taken on the last sample of the first byte's bit 0.
    act = 0;
    if (tx_active === 1'b1) act++;
    step(1'b1, 8'h0F, 1'b0, 12'sd77, acc);
    k = 0;
    acc = 1'b0;
    while (!acc && k < 40 * L) begin
      if (tx_active === 1'b1) act++;
      step(1'b1, 8'hF0, 1'b1, 12'sd77, acc);
      k++;
    end
    check("b2b_accept_cycle", k, (P + 8) * L);
    for (int i = 0; i < 8 * L + 4; i++) begin
      if (tx_active === 1'b1) act++;
      step(1'b0, 8'h00, 1'b0, 12'sd77, acc);
    end
    check("b2b_active_cycles", act, (P + 16) * L);

    // Asynchronous reset in the middle of data bit 3.
    step(1'b1, 8'hC3, 1'b0, 12'sd200, acc);
    repeat ((P + 4) * L + 5) step(1'b0, 8'h00, 1'b0, 12'sd200, acc);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_tx_sig", tx_sig, 0);
    check("async_rst_tx_active", {31'b0, tx_active}, 0);
    check("async_rst_ready", {31'b0, data_ready}, 0);
    q.delete();
    pos = 0;
    exp_tx = '0;
    exp_active = 1'b0;
    exp_strobe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    single_byte(8'h3C, 1'b0, 12'sd123);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 2) == 0, 8'($urandom), 1'($urandom_range(0, 1)), rnd_sine(), acc);
    repeat (16 * L + 4) step(1'b0, 8'h00, 1'b0, rnd_sine(), acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
